// File: rtl/key_debounce_pkg.sv
// Shared sizing helpers for the key debouncer: counter widths and ms-to-clock conversion.
package key_debounce_pkg;

    localparam int CLKS_PER_MS_PER_MHZ = 1000;

    // Bits needed to hold max_value; never below one so degenerate counters still exist.
    function automatic int cnt_width(input int max_value);
        return (max_value < 2) ? 1 : $clog2(max_value + 1);
    endfunction

    function automatic int ms_to_count(input int clk_freq_mhz);
        return clk_freq_mhz * CLKS_PER_MS_PER_MHZ;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-clock tick once per millisecond.
module ms_tick_gen
    import key_debounce_pkg::*;
#(
    parameter int CLK_FREQ_MHZ = 50
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int TERMINAL = ms_to_count(CLK_FREQ_MHZ) - 1;
    localparam int W        = cnt_width(TERMINAL);

    logic [W-1:0] count;

    assign tick = (count == W'(TERMINAL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/key_debounce_array.sv
// Array of independent key debouncers with press/release/long-press event pulses,
// all channels sharing one millisecond tick.
module key_debounce_array
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS      = 4,
    parameter int CLK_FREQ_MHZ  = 50,
    parameter int DEBOUNCE_MS   = 20,
    parameter int LONG_PRESS_MS = 1000,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_in,
    output logic [NUM_KEYS-1:0] key_pressed,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    localparam logic RELEASED_LEVEL = (ACTIVE_LOW != 0);
    localparam int   DEB_MAX        = DEBOUNCE_MS - 1;
    localparam int   DEB_W          = cnt_width(DEB_MAX);
    localparam int   LONG_TH        = LONG_PRESS_MS - DEBOUNCE_MS;
    localparam int   HOLD_W         = cnt_width(LONG_TH);

    logic                tick;
    logic [NUM_KEYS-1:0] sync_meta;
    logic [NUM_KEYS-1:0] sync_out;
    logic [NUM_KEYS-1:0] raw_n;

    ms_tick_gen #(
        .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    // Synchronisers reset to the idle pin level so nothing looks pressed coming out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= {NUM_KEYS{RELEASED_LEVEL}};
            sync_out  <= {NUM_KEYS{RELEASED_LEVEL}};
        end else begin
            sync_meta <= key_in;
            sync_out  <= sync_meta;
        end
    end

    assign raw_n = (ACTIVE_LOW != 0) ? ~sync_out : sync_out;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        logic [DEB_W-1:0]  deb_cnt;
        logic [HOLD_W-1:0] hold_cnt;
        logic              pressed_q;
        logic              press_q;
        logic              release_q;
        logic              long_q;
        logic              differ;
        logic              accept;
        logic              long_hit;

        assign differ   = (raw_n[i] != pressed_q);
        assign accept   = differ && tick && (deb_cnt == DEB_W'(DEB_MAX));
        assign long_hit = pressed_q && tick && (hold_cnt == HOLD_W'(LONG_TH - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_cnt   <= '0;
                pressed_q <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                if (!differ || accept) begin
                    deb_cnt <= '0;
                end else if (tick) begin
                    deb_cnt <= deb_cnt + DEB_W'(1);
                end
                if (accept) begin
                    pressed_q <= raw_n[i];
                end
                press_q   <= accept && raw_n[i];
                release_q <= accept && !raw_n[i];
            end
        end

        // A release accepted on the very tick that would complete the hold suppresses key_long.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_cnt <= '0;
                long_q   <= 1'b0;
            end else begin
                if (!pressed_q) begin
                    hold_cnt <= '0;
                end else if (tick && (hold_cnt != HOLD_W'(LONG_TH))) begin
                    hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                long_q <= long_hit && !accept;
            end
        end

        assign key_pressed[i] = pressed_q;
        assign key_press[i]   = press_q;
        assign key_release[i] = release_q;
        assign key_long[i]    = long_q;
    end

endmodule
